// File: rtl/in_deser.sv
// Serial-to-parallel input deserializer with sync-word alignment and valid/ready output.
// Optional bitslip port and logic enabled by defining IN_DESER_BITSLIP_EN.
//
// state   | meaning
// HUNT    | searching shifted stream for SYNC_WORD, locked=0, no words emitted
// LOCK    | aligned, counting WIDTH bits per word, locked=1
module in_deser #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD = WIDTH'(8'hA5),
  parameter bit              MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dataIn,
  input  logic             en,
  input  logic             align_req,
  input  logic             ready,
`ifdef IN_DESER_BITSLIP_EN
  input  logic             bitslip,
`endif
  output logic [WIDTH-1:0] dataOut,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {ST_HUNT, ST_LOCK} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;

  logic [WIDTH-1:0] w_next;
  logic             w_slip;
  logic             w_shift;
  logic             w_match;
  logic             w_complete;
  logic             w_take;

`ifdef IN_DESER_BITSLIP_EN
  assign w_slip = bitslip;
`else
  assign w_slip = 1'b0;
`endif

  always_comb begin
    w_next = r_sreg;
    if (MSB_FIRST) w_next = {r_sreg[WIDTH-2:0], dataIn};
    else           w_next = {dataIn, r_sreg[WIDTH-1:1]};
  end

  // A slipped bit is simply never shifted in; align_req overrides the slip.
  assign w_shift    = en && !((r_state == ST_LOCK) && w_slip && !align_req);
  assign w_match    = w_shift && (r_state == ST_HUNT) && !align_req && (w_next == SYNC_WORD);
  assign w_complete = w_shift && (r_state == ST_LOCK) && !align_req &&
                      (r_bit_cnt == CW'(WIDTH-1));
  assign w_take     = r_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_HUNT;
      r_sreg     <= '0;
      r_bit_cnt  <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_shift) r_sreg <= w_next;

      if (align_req) begin
        r_state   <= ST_HUNT;
        r_bit_cnt <= '0;
      end else if (r_state == ST_HUNT) begin
        if (w_match) begin
          r_state   <= ST_LOCK;
          r_bit_cnt <= '0;
        end
      end else if (w_shift) begin
        r_bit_cnt <= w_complete ? '0 : r_bit_cnt + 1'b1;
      end

      // Holding register is free when empty or being drained this same edge.
      if (w_complete && (!r_valid || ready)) begin
        r_data  <= w_next;
        r_valid <= 1'b1;
      end else begin
        if (w_complete) r_overflow <= 1'b1;
        if (w_take)     r_valid    <= 1'b0;
      end
    end
  end

  assign dataOut  = r_data;
  assign valid    = r_valid;
  assign locked   = (r_state == ST_LOCK);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_in_deser.sv
// Self-checking bench for in_deser: queue-based reference model plus directed literal checks.
module tb_in_deser;

  localparam int W = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dataIn = 1'b0;
  logic       en = 1'b0;
  logic       align_req = 1'b0;
  logic       ready = 1'b0;
  logic       bitslip = 1'b0;

  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, locked_m, locked_l, ovf_m, ovf_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  in_deser #(.WIDTH(W), .SYNC_WORD(SYNC), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .en(en), .align_req(align_req), .ready(ready),
`ifdef IN_DESER_BITSLIP_EN
    .bitslip(bitslip),
`endif
    .dataOut(dout_m), .valid(valid_m), .locked(locked_m), .overflow(ovf_m)
  );

  in_deser #(.WIDTH(W), .SYNC_WORD(SYNC), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .en(en), .align_req(align_req), .ready(ready),
`ifdef IN_DESER_BITSLIP_EN
    .bitslip(bitslip),
`endif
    .dataOut(dout_l), .valid(valid_l), .locked(locked_l), .overflow(ovf_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = MSB-first instance, 1 = LSB-first instance.
  bit         m_hist [2][$];
  bit         m_lock [2];
  int         m_n    [2];
  logic [7:0] m_data [2];
  bit         m_valid[2];
  bit         m_ovf  [2];

  function automatic logic [7:0] word_of(input int m);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (m == 0) w[W-1-i] = m_hist[m][i];
      else        w[i]     = m_hist[m][i];
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_hist[m].delete();
        for (int i = 0; i < W; i++) m_hist[m].push_back(1'b0);
        m_lock[m] = 0; m_n[m] = 0; m_data[m] = '0; m_valid[m] = 0; m_ovf[m] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit newword;
        newword = 0;
        if (en && !(m_lock[m] && bitslip && !align_req)) begin
          m_hist[m].push_back(dataIn);
          void'(m_hist[m].pop_front());
          if (!align_req) begin
            if (!m_lock[m]) begin
              if (word_of(m) == SYNC) begin
                m_lock[m] = 1;
                m_n[m] = 0;
              end
            end else begin
              m_n[m]++;
              if (m_n[m] == W) begin
                m_n[m] = 0;
                newword = 1;
              end
            end
          end
        end
        if (align_req) begin
          m_lock[m] = 0;
          m_n[m] = 0;
        end
        if (newword) begin
          if (!m_valid[m] || ready) begin
            m_data[m]  = word_of(m);
            m_valid[m] = 1;
          end else begin
            m_ovf[m] = 1;
          end
        end else if (m_valid[m] && ready) begin
          m_valid[m] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_data_msb",   {24'b0, dout_m},   {24'b0, m_data[0]});
      chk("cyc_valid_msb",  {31'b0, valid_m},  {31'b0, m_valid[0]});
      chk("cyc_locked_msb", {31'b0, locked_m}, {31'b0, m_lock[0]});
      chk("cyc_ovf_msb",    {31'b0, ovf_m},    {31'b0, m_ovf[0]});
      chk("cyc_data_lsb",   {24'b0, dout_l},   {24'b0, m_data[1]});
      chk("cyc_valid_lsb",  {31'b0, valid_l},  {31'b0, m_valid[1]});
      chk("cyc_locked_lsb", {31'b0, locked_l}, {31'b0, m_lock[1]});
      chk("cyc_ovf_lsb",    {31'b0, ovf_l},    {31'b0, m_ovf[1]});
    end
  end

  task automatic drv(input logic d, input logic e, input logic r, input logic a, input logic s);
    @(negedge clk);
    dataIn = d; en = e; ready = r; align_req = a; bitslip = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic r);
    for (int i = 7; i >= 0; i--) drv(v[i], 1'b1, r, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; align_req = 1'b0; bitslip = 1'b0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_data",   {24'b0, dout_m},  32'h0);
    chk("rst_valid",  {31'b0, valid_m}, 32'h0);
    chk("rst_locked", {31'b0, locked_m}, 32'h0);
    chk("rst_ovf",    {31'b0, ovf_m},   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on A5, then first word 3C, MSB-first
    for (int i = 7; i >= 1; i--) drv(SYNC[i], 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lock_before_8th", {31'b0, locked_m}, 32'h0);
    drv(SYNC[0], 1'b1, 1'b1, 1'b0, 1'b0);
    chk("lock_after_8th", {31'b0, locked_m}, 32'h1);
    send_byte(8'h3C, 1'b1);
    chk("first_word_valid", {31'b0, valid_m}, 32'h1);
    chk("first_word_data",  {24'b0, dout_m},  32'h3C);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("first_word_drained", {31'b0, valid_m}, 32'h0);

    // LSB-first assembly
    do_reset();
    send_byte(8'b1010_0101, 1'b1);
    chk("lsb_locked", {31'b0, locked_l}, 32'h1);
    send_byte(8'b0100_1000, 1'b1);
    chk("lsb_data",  {24'b0, dout_l},  32'h12);
    chk("lsb_valid", {31'b0, valid_l}, 32'h1);

    // Backpressure and overflow
    do_reset();
    send_byte(SYNC, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("bp_first_data", {24'b0, dout_m}, 32'h11);
    chk("bp_first_ovf",  {31'b0, ovf_m},  32'h0);
    send_byte(8'h22, 1'b0);
    chk("bp_hold_data",  {24'b0, dout_m},  32'h11);
    chk("bp_hold_valid", {31'b0, valid_m}, 32'h1);
    chk("bp_ovf_set",    {31'b0, ovf_m},   32'h1);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained",   {31'b0, valid_m}, 32'h0);
    chk("bp_ovf_stuck", {31'b0, ovf_m},   32'h1);
    chk("bp_data_kept", {24'b0, dout_m},  32'h11);

    // Transfer and completion on the same edge
    do_reset();
    send_byte(SYNC, 1'b0);
    send_byte(8'h11, 1'b0);
    for (int i = 7; i >= 0; i--) drv(logic'((8'h22 >> i) & 1), 1'b1, (i == 0), 1'b0, 1'b0);
    chk("simul_data",  {24'b0, dout_m},  32'h22);
    chk("simul_valid", {31'b0, valid_m}, 32'h1);
    chk("simul_ovf",   {31'b0, ovf_m},   32'h0);

    // Mid-word realign, held word survives, gapped relock
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("realign_unlocked", {31'b0, locked_m}, 32'h0);
    chk("realign_held",     {24'b0, dout_m},   32'h22);
    chk("realign_valid",    {31'b0, valid_m},  32'h1);
    for (int i = 7; i >= 0; i--) begin
      drv(SYNC[i], 1'b1, 1'b1, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("relock", {31'b0, locked_m}, 32'h1);
    for (int i = 7; i >= 0; i--) begin
      drv(logic'((8'h5A >> i) & 1), 1'b1, 1'b1, 1'b0, 1'b0);
      if (i != 0) drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("gapped_data",  {24'b0, dout_m},  32'h5A);
    chk("gapped_valid", {31'b0, valid_m}, 32'h1);

    // Async reset between edges with a word held
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_data",   {24'b0, dout_m},   32'h0);
    chk("async_rst_valid",  {31'b0, valid_m},  32'h0);
    chk("async_rst_locked", {31'b0, locked_m}, 32'h0);
    chk("async_rst_ovf",    {31'b0, ovf_m},    32'h0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IN_DESER_BITSLIP_EN
    // One slipped zero at bit 3: nine bits sent, eight assembled
    send_byte(SYNC, 1'b1);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("slip_no_word", {31'b0, valid_m}, 32'h0);
    drv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("slip_data",  {24'b0, dout_m},  32'h0F);
    chk("slip_valid", {31'b0, valid_m}, 32'h1);
`endif

    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
